// File: rtl/alu_dsp_sequencer.sv
// Issue/retire sequencer around the AluDsp48 ALU: decodes tagged requests, spaces
// ALU/MUL returns so they never collide, re-tags results. Option: ALU_DSP_SEQ_CHECK_EN.
module alu_dsp_sequencer #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 11,
    parameter int ALU_LAT = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_funct,
    input  logic [DATA_W-1:0]   req_op0,
    input  logic [DATA_W-1:0]   req_op1,
    input  logic                req_cin,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [DATA_W-1:0]   dsp_in0,
    output logic [DATA_W-1:0]   dsp_in1,
    output logic [DATA_W-1:0]   dsp_in2,
    output logic                dsp_carryin,
    output logic [8:0]          dsp_opmode,
    output logic [3:0]          dsp_alumode,
    output logic [1:0]          dsp_setinst,
    output logic                dsp_valid_in,
    input  logic [DATA_W-1:0]   dsp_out,
    input  logic [2*DATA_W-1:0] dsp_mul_out,
    input  logic                dsp_carryout,
    input  logic                dsp_valid_out,
    output logic                rsp_valid,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [DATA_W-1:0]   rsp_data_hi,
    output logic                rsp_carry,
    output logic                rsp_is_mul,
    output logic                err_orphan,
    output logic                err_missing,
    output logic                err_illegal
);
    localparam int DRAIN_W = $clog2(MUL_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MUL_LAT);

    localparam logic [3:0] F_AND  = 4'd0;
    localparam logic [3:0] F_OR   = 4'd1;
    localparam logic [3:0] F_XOR  = 4'd2;
    localparam logic [3:0] F_ADDC = 4'd4;
    localparam logic [3:0] F_SUB  = 4'd5;
    localparam logic [3:0] F_MUL  = 4'd6;
    localparam logic [3:0] F_SEQ  = 4'd7;
    localparam logic [3:0] F_SLTU = 4'd8;
    localparam logic [3:0] F_SLTS = 4'd9;

    localparam logic [8:0] OPM_ALU = 9'b000110011;
    localparam logic [8:0] OPM_OR  = 9'b000111011;
    localparam logic [8:0] OPM_MUL = 9'b000000101;

    typedef struct packed {
        logic             vld;
        logic             mul;
        logic [TAG_W-1:0] tag;
    } slot_t;

    // Slot 0 is the cycle in which dsp_valid_out is expected; slots 1..MUL_LAT count down to it.
    slot_t slot_q [0:MUL_LAT];
    slot_t slot_d [0:MUL_LAT];

    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [DATA_W-1:0]  in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;
    logic               cin_q, cin_d, vin_q, vin_d;
    logic [8:0]         opmode_q, opmode_d;
    logic [3:0]         alumode_q, alumode_d;
    logic [1:0]         setinst_q, setinst_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_mul_q, rsp_mul_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d, rsp_hi_q, rsp_hi_d;
    logic               orphan_q, orphan_d, missing_q, missing_d, illegal_q, illegal_d;

    logic is_mul, legal, accept, issue, draining, dv, take;

    always_comb begin
        is_mul    = (req_funct == F_MUL);
        legal     = (req_funct <= F_SLTS);
        draining  = (drain_q != '0);
        // An ALU op lands in slot ALU_LAT after the shift, which is where slot ALU_LAT+1 moves to.
        req_ready = !reset && !draining && !(legal && !is_mul && slot_q[ALU_LAT+1].vld);
        accept    = req_valid && req_ready;
        issue     = accept && legal;
    end

    always_comb begin
        in0_d     = '0;
        in1_d     = '0;
        in2_d     = '0;
        cin_d     = 1'b0;
        vin_d     = issue;
        opmode_d  = opmode_q;
        alumode_d = alumode_q;
        setinst_d = setinst_q;
        if (issue) begin
            in0_d     = req_op0;
            in1_d     = req_op1;
            opmode_d  = OPM_ALU;
            alumode_d = 4'b0000;
            setinst_d = 2'b00;
            case (req_funct)
                F_AND:  alumode_d = 4'b1100;
                F_OR: begin
                    opmode_d  = OPM_OR;
                    alumode_d = 4'b1100;
                end
                F_XOR:  alumode_d = 4'b0100;
                F_ADDC: cin_d = req_cin;
                F_SUB:  alumode_d = 4'b0011;
                F_SEQ: begin
                    alumode_d = 4'b0011;
                    setinst_d = 2'b01;
                end
                F_SLTU: begin
                    alumode_d = 4'b0011;
                    setinst_d = 2'b10;
                end
                F_SLTS: begin
                    alumode_d = 4'b0011;
                    setinst_d = 2'b11;
                end
                F_MUL: begin
                    in0_d    = '0;
                    in1_d    = req_op0;
                    in2_d    = req_op1;
                    opmode_d = OPM_MUL;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < MUL_LAT; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        slot_d[MUL_LAT] = '0;
        if (issue) begin
            if (is_mul) begin
                slot_d[MUL_LAT] = {1'b1, 1'b1, req_tag};
            end else begin
                slot_d[ALU_LAT] = {1'b1, 1'b0, req_tag};
            end
        end
        drain_d = draining ? drain_q - 1'b1 : drain_q;
    end

    always_comb begin
        // Results seen during the drain window belong to ops issued before reset.
        dv = dsp_valid_out && !draining;
`ifdef ALU_DSP_SEQ_CHECK_EN
        take      = dv && slot_q[0].vld;
        orphan_d  = orphan_q | (dv && !slot_q[0].vld);
        missing_d = missing_q | (slot_q[0].vld && !dsp_valid_out);
`else
        take      = dv;
        orphan_d  = 1'b0;
        missing_d = 1'b0;
`endif
        illegal_d   = illegal_q | (accept && !legal);
        rsp_valid_d = take;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_carry_d = rsp_carry_q;
        rsp_mul_d   = rsp_mul_q;
        if (take) begin
            rsp_tag_d   = slot_q[0].tag;
            rsp_mul_d   = slot_q[0].mul;
            rsp_data_d  = slot_q[0].mul ? dsp_mul_out[DATA_W-1:0] : dsp_out;
            rsp_hi_d    = slot_q[0].mul ? dsp_mul_out[2*DATA_W-1:DATA_W] : '0;
            rsp_carry_d = slot_q[0].mul ? 1'b0 : dsp_carryout;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                slot_q[i] <= '0;
            end
            drain_q     <= DRAIN_INIT;
            in0_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            cin_q       <= 1'b0;
            vin_q       <= 1'b0;
            opmode_q    <= '0;
            alumode_q   <= '0;
            setinst_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            rsp_hi_q    <= '0;
            rsp_carry_q <= 1'b0;
            rsp_mul_q   <= 1'b0;
            orphan_q    <= 1'b0;
            missing_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                slot_q[i] <= slot_d[i];
            end
            drain_q     <= drain_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            cin_q       <= cin_d;
            vin_q       <= vin_d;
            opmode_q    <= opmode_d;
            alumode_q   <= alumode_d;
            setinst_q   <= setinst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_mul_q   <= rsp_mul_d;
            orphan_q    <= orphan_d;
            missing_q   <= missing_d;
            illegal_q   <= illegal_d;
        end
    end

    assign dsp_in0      = in0_q;
    assign dsp_in1      = in1_q;
    assign dsp_in2      = in2_q;
    assign dsp_carryin  = cin_q;
    assign dsp_valid_in = vin_q;
    assign dsp_opmode   = opmode_q;
    assign dsp_alumode  = alumode_q;
    assign dsp_setinst  = setinst_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_data_hi  = rsp_hi_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_is_mul   = rsp_mul_q;
    assign err_orphan   = orphan_q;
    assign err_missing  = missing_q;
    assign err_illegal  = illegal_q;

endmodule
